// File: rtl/ram_stream_reader.sv
// Streams len consecutive words out of a synchronous-read RAM onto a valid/ready
// port. A 2-entry FIFO plus credit-gated issue keeps RAM data safe under backpressure.
module ram_stream_reader #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   len,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);
  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  typedef struct packed {
    logic              last;
    logic [DWIDTH-1:0] data;
  } beat_t;

  state_t            state;
  logic [AWIDTH-1:0] base_q, addr_q, issue_addr;
  logic [AWIDTH:0]   len_q, issued;
  logic              inflight, inflight_last;
  beat_t             head, tail, din_beat;
  logic [1:0]        count;
  logic [2:0]        credit;
  logic              pop, push, issue, issue_last;

  assign ram_din  = '0;
  assign ram_we   = 1'b0;

  assign out_valid = (count != 2'd0);
  assign out_data  = head.data;
  assign out_last  = head.last & out_valid;
  assign busy      = (state == READ) || (state == DRAIN);
  assign done      = (state == DONE);

  assign pop  = out_valid & out_ready;
  assign push = inflight;
  // Slots already owed: entries held plus the word on its way back from the RAM.
  assign credit     = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue      = (state == READ) && (issued != len_q) && (credit < 3'd2);
  assign issue_last = (issued + (AWIDTH+1)'(1)) == len_q;
  assign issue_addr = base_q + issued[AWIDTH-1:0];
  // The RAM latches the address at the end of the issue cycle, so drive it now.
  assign ram_addr   = issue ? issue_addr : addr_q;
  assign din_beat   = '{last: inflight_last, data: ram_dout};

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      base_q        <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      issued        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          base_q <= base_addr;
          len_q  <= (len > DEPTH_L) ? DEPTH_L : len;
          issued <= '0;
          state  <= (len == '0) ? DONE : READ;
        end
        READ: if (issue) begin
          issued <= issued + (AWIDTH+1)'(1);
          if (issue_last) state <= DRAIN;
        end
        DRAIN: if (!inflight && count == 2'd0) state <= DONE;
        default: state <= IDLE;
      endcase

      if (issue) addr_q <= issue_addr;
      inflight      <= issue;
      inflight_last <= issue & issue_last;

      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din_beat;
          else               tail <= din_beat;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) head <= din_beat;
          else begin
            head <= tail;
            tail <= din_beat;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench: behavioural RAM plus a queue-based model of the expected stream.
module tb_ram_stream_reader;
  logic        clock = 1'b0;
  logic        reset, start, out_ready;
  logic [2:0]  base_addr, ram_addr;
  logic [3:0]  len;
  logic        busy, done, ram_we, out_valid, out_last;
  logic [31:0] ram_din, ram_dout, out_data;

  logic [31:0] mem [8];
  logic [2:0]  ram_addr_q = '0;
  logic [31:0] got_d [$];
  logic        got_l [$];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  always @(posedge clock) ram_addr_q <= ram_addr;
  assign ram_dout = mem[ram_addr_q];

  ram_stream_reader #(.AWIDTH(3), .DWIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  task automatic preload();
    for (int i = 0; i < 8; i++) mem[i] = 32'h100 + i;
  endtask

  // Drives one command and records accepted beats; mode 0 ready, 1 = 1,0,0 pattern, 2 random.
  task automatic run_cmd(input logic [2:0] b, input logic [3:0] l, input int mode,
                         input bit restart, output int first_valid, output int done_cnt,
                         output int done_cyc, output int busy0, output int stall_err,
                         output bit timeout);
    bit prev_stall, pl;
    logic [31:0] pd;
    got_d.delete(); got_l.delete();
    first_valid = -1; done_cnt = 0; done_cyc = -1; stall_err = 0; timeout = 1;
    busy0 = 0; prev_stall = 0; pd = '0; pl = 0;
    out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    base_addr = b; len = l; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clock);
      if (cyc == 0) busy0 = int'(busy);
      if (prev_stall && (!out_valid || out_data !== pd || out_last !== pl)) stall_err++;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      prev_stall = out_valid && !out_ready; pd = out_data; pl = out_last;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) begin
        timeout = 0;
        break;
      end
      @(posedge clock); #1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc + 1) % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (restart && cyc == 1) begin
        start = 1'b1; base_addr = 3'd5; len = 4'd3;
      end else start = 1'b0;
    end
    out_ready = 1'b1;
  endtask

  // Runs a command and compares it against the modular-address model.
  task automatic test_command(input logic [2:0] b, input logic [3:0] l, input int mode,
                              input bit restart);
    int fv, dc, dcyc, b0, se, n;
    bit to;
    logic [31:0] exp_d [$];
    logic        exp_l [$];
    n = (l > 8) ? 8 : int'(l);
    for (int i = 0; i < n; i++) begin
      exp_d.push_back(mem[(int'(b) + i) % 8]);
      exp_l.push_back(i == n - 1);
    end
    run_cmd(b, l, mode, restart, fv, dc, dcyc, b0, se, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL timeout b=%0d l=%0d: no done within budget", b, l);
    end
    checks++;
    if (got_d.size() !== n) begin
      errors++;
      $display("FAIL beat_count b=%0d l=%0d got %0d exp %0d", b, l, got_d.size(), n);
    end
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL beat b=%0d l=%0d idx %0d got %h/%0b exp %h/%0b",
                 b, l, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (dc !== 1) begin
      errors++;
      $display("FAIL done_count b=%0d l=%0d got %0d exp 1", b, l, dc);
    end
    checks++;
    if (se !== 0) begin
      errors++;
      $display("FAIL stall_stability b=%0d l=%0d got %0d changes exp 0", b, l, se);
    end
    checks++;
    if (b0 !== int'(n > 0)) begin
      errors++;
      $display("FAIL busy_after_start b=%0d l=%0d got %0d exp %0d", b, l, b0, int'(n > 0));
    end
    if (mode == 0) begin
      checks++;
      if (fv !== ((n > 0) ? 2 : -1)) begin
        errors++;
        $display("FAIL first_valid b=%0d l=%0d got %0d exp %0d", b, l, fv, (n > 0) ? 2 : -1);
      end
      checks++;
      if (dcyc !== ((n > 0) ? n + 3 : 0)) begin
        errors++;
        $display("FAIL done_cycle b=%0d l=%0d got %0d exp %0d", b, l, dcyc, (n > 0) ? n + 3 : 0);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b1; base_addr = '0; len = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({busy, done, out_valid, out_last, ram_we} !== 5'b0 || out_data !== 32'h0 ||
        ram_addr !== 3'h0 || ram_din !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b valid=%b last=%b data=%h addr=%h exp all 0",
               busy, done, out_valid, out_last, out_data, ram_addr);
    end
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic test_basic();
    test_command(3'd2, 4'd3, 0, 0);
    test_command(3'd6, 4'd4, 0, 0);
    test_command(3'd7, 4'd2, 0, 0);
  endtask

  task automatic test_backpressure();
    test_command(3'd0, 4'd8, 1, 0);
  endtask

  task automatic test_len_edges();
    test_command(3'd3, 4'd0, 0, 0);
    test_command(3'd4, 4'd12, 0, 0);
  endtask

  task automatic test_start_ignored();
    test_command(3'd0, 4'd5, 0, 1);
  endtask

  task automatic test_reset_abort();
    int beats, quiet_bad;
    beats = 0; quiet_bad = 0;
    out_ready = 1'b1; base_addr = 3'd0; len = 4'd6; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int cyc = 0; cyc < 40 && beats < 2; cyc++) begin
      @(negedge clock);
      if (out_valid && out_ready) beats++;
      if (beats < 2) @(posedge clock);
    end
    checks++;
    if (beats !== 2) begin
      errors++;
      $display("FAIL abort_setup got %0d beats exp 2", beats);
    end
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got valid=%b busy=%b done=%b exp 0 0 0", out_valid, busy, done);
    end
    repeat (6) begin
      @(negedge clock);
      if (out_valid || done || busy) quiet_bad++;
    end
    checks++;
    if (quiet_bad !== 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d active cycles exp 0", quiet_bad);
    end
    @(posedge clock); #1;
    test_command(3'd1, 4'd1, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 8; i++) mem[i] = $urandom;
      test_command(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 2, 0);
    end
  endtask

  initial begin
    preload();
    test_reset();
    test_basic();
    test_backpressure();
    test_len_edges();
    test_start_ignored();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read initiator for the single-port, synchronous-read RAM, which has 1-cycle read latency and a latched read address.
- On a start command it fetches len consecutive words beginning at base_addr, wrapping modulo DEPTH.
- It presents the words on a valid/ready output stream, marking the final word with out_last.
- A 2-entry output FIFO with credit-based issue absorbs downstream backpressure without losing RAM data.

Parameters:
- AWIDTH, 3, RAM address width; DEPTH = 1 << AWIDTH (localparam).
- DWIDTH, 32, RAM and stream data width.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  AWIDTH  first word address; captured with start.
- len  in  AWIDTH+1  word count; 0 = no-op; values > DEPTH are clipped to DEPTH.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- ram_addr  out  AWIDTH  address to RAM addr.
- ram_din  out  DWIDTH  tied 0.
- ram_we  out  1  tied 0; this block never writes.
- ram_dout  in  DWIDTH  RAM read data, valid one cycle after ram_addr is registered.
- out_data  out  DWIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from consumer.
- out_last  out  1  high with the final word of a command.

Behaviour:
- Reset:
  - State goes to IDLE; FIFO is emptied; in-flight flag and counters are cleared.
  - Outputs: busy=0, done=0, out_valid=0, out_last=0, out_data=0, ram_addr=0.
  - Reset mid-command aborts it: no further beats, no done pulse.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 captures base_addr and min(len, DEPTH).
  - len=0 goes to DONE; otherwise goes to READ.
- READ:
  - Issue a read when (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready.
  - An issue drives ram_addr = base_addr + issued_count (mod DEPTH), sets inflight for the next cycle, and increments issued_count.
  - When not issuing, ram_addr holds its last value.
  - Moves to DRAIN in the cycle after the final issue.
- Data capture: ram_dout is pushed into the FIFO on the edge ending any cycle where inflight=1. The credit rule guarantees the push never overflows.
- DRAIN: waits until inflight=0 and the FIFO is empty, with the last beat accepted, then moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in the DONE cycle.
- Latency: with start sampled at edge E0, the first address is driven after E0, the RAM latches it at E1, and the FIFO captures it at E2. out_valid is first high in the cycle after E2.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Stream rules:
  - out_data, out_valid and out_last stay stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake.
  - out_last=1 only on the len-th word.
- start while busy is ignored.
- Address wrap: base_addr=DEPTH-1 with len=2 reads DEPTH-1, then 0.
- Simultaneous push and pop on the same edge keeps fifo_count unchanged.

Test Plan:
- Preload mem[i]=0x100+i; start with base=2, len=3, out_ready=1 -> out_data 0x102, 0x103, 0x104 on consecutive cycles; first valid 2 edges after start; out_last on 0x104; done pulses once afterwards.
- base=6, len=4, out_ready=1 -> 0x106, 0x107, 0x100, 0x101 (wrap); out_last on 0x101.
- base=0, len=8, out_ready toggling 1,0,0,1,... -> all 8 words in order with no loss or duplication; out_data held stable while stalled; fifo never exceeds 2 entries.
- len=0 -> no out_valid; done=1 exactly one cycle after start; len=12 -> clipped to 8 beats.
- Pulse start again mid-command with base=5 -> ignored; original sequence completes unchanged.
- Assert reset after the 2nd beat of a len=6 command -> the cycle after the reset edge has out_valid=0, busy=0, no done; a new start with base=1, len=1 then returns 0x101 with out_last=1.
